// File: rtl/fpm_round_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fpm_round_wb
// Brief    : Half-precision multiplier back end. Normalises and rounds a raw
//            11x11 significand product, then queues results for writeback.
// Revision : 1.0 - initial release
// ============================================================================
module fpm_round_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [4:0]  in_exp_a,
    input  logic [4:0]  in_exp_b,
    input  logic [21:0] in_prod,
    input  logic [2:0]  in_tag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_tag,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_inexact
);

    localparam int                 c_DEPTH   = 4;
    localparam int                 c_PTR_W   = 2;
    localparam int                 c_CNT_W   = 3;
    localparam logic [c_CNT_W:0]   c_SLOTS   = 4'd4;
    localparam logic signed [6:0]  c_BIAS    = 7'sd15;
    localparam logic signed [6:0]  c_EXP_MAX = 7'sd31;
    localparam logic signed [6:0]  c_EXP_MIN = 7'sd0;

    typedef struct packed {
        logic [2:0]  tag;
        logic        ovf;
        logic        unf;
        logic        inexact;
        logic [15:0] result;
    } entry_t;

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    logic        r_run;
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [4:0]  r_s1_exp_a;
    logic [4:0]  r_s1_exp_b;
    logic [21:0] r_s1_prod;
    logic [2:0]  r_s1_tag;

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    entry_t             r_mem [c_DEPTH];

    logic w_accept;
    logic w_push;
    logic w_pop;

    // Occupancy counts both the stage-1 slot and the FIFO so a held S1 entry
    // always has a FIFO slot waiting for it, whatever the consumer does.
    assign in_ready = r_run && (({1'b0, r_count} + {{c_CNT_W{1'b0}}, r_s1_valid}) < c_SLOTS);
    assign w_accept = in_valid && in_ready;
    assign w_push   = r_s1_valid;
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp_a <= 5'd0;
            r_s1_exp_b <= 5'd0;
            r_s1_prod  <= 22'd0;
            r_s1_tag   <= 3'd0;
        end else begin
            r_run      <= 1'b1;
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sign  <= in_sign;
                r_s1_exp_a <= in_exp_a;
                r_s1_exp_b <= in_exp_b;
                r_s1_prod  <= in_prod;
                r_s1_tag   <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Normalise and round-to-nearest-even
    // ------------------------------------------------------------------
    logic              w_inc;
    logic [9:0]        w_mant_raw;
    logic              w_guard;
    logic              w_sticky;
    logic              w_rup;
    logic [10:0]       w_mant_sum;
    logic              w_carry;
    logic [9:0]        w_mant;
    logic signed [6:0] w_exp;
    entry_t            w_entry;

    always_comb begin
        w_inc      = r_s1_prod[21];
        w_mant_raw = w_inc ? r_s1_prod[20:11] : r_s1_prod[19:10];
        w_guard    = w_inc ? r_s1_prod[10]    : r_s1_prod[9];
        w_sticky   = w_inc ? (|r_s1_prod[9:0]) : (|r_s1_prod[8:0]);
        w_rup      = w_guard && (w_sticky || w_mant_raw[0]);
        w_mant_sum = {1'b0, w_mant_raw} + {10'd0, w_rup};
        w_carry    = w_mant_sum[10];
        w_mant     = w_carry ? 10'd0 : w_mant_sum[9:0];
        w_exp      = $signed({2'b00, r_s1_exp_a}) + $signed({2'b00, r_s1_exp_b})
                   - c_BIAS + $signed({6'd0, w_inc}) + $signed({6'd0, w_carry});
    end

    always_comb begin
        w_entry.tag     = r_s1_tag;
        w_entry.ovf     = 1'b0;
        w_entry.unf     = 1'b0;
        w_entry.inexact = 1'b0;
        w_entry.result  = {r_s1_sign, 15'd0};
        if ((r_s1_exp_a == 5'd0) || (r_s1_exp_b == 5'd0)) begin
            w_entry.result = {r_s1_sign, 15'd0};
        end else if ((r_s1_exp_a == 5'h1F) || (r_s1_exp_b == 5'h1F)) begin
            w_entry.result = {r_s1_sign, 5'h1F, 10'd0};
        end else if (w_exp >= c_EXP_MAX) begin
            w_entry.result  = {r_s1_sign, 5'h1F, 10'd0};
            w_entry.ovf     = 1'b1;
            w_entry.inexact = 1'b1;
        end else if (w_exp <= c_EXP_MIN) begin
            // No subnormal support: anything below the normal range flushes.
            w_entry.result  = {r_s1_sign, 15'd0};
            w_entry.unf     = 1'b1;
            w_entry.inexact = 1'b1;
        end else begin
            w_entry.result  = {r_s1_sign, w_exp[4:0], w_mant};
            w_entry.inexact = w_guard || w_sticky;
        end
    end

    // ------------------------------------------------------------------
    // In-order output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Storage is not reset; gating with out_valid keeps stale data off the bus.
    entry_t w_head;
    assign w_head      = r_mem[r_rd_ptr];
    assign out_valid   = (r_count != '0);
    assign out_result  = out_valid ? w_head.result  : 16'd0;
    assign out_tag     = out_valid ? w_head.tag     : 3'd0;
    assign out_ovf     = out_valid && w_head.ovf;
    assign out_unf     = out_valid && w_head.unf;
    assign out_inexact = out_valid && w_head.inexact;

endmodule
`default_nettype wire

// File: tb/tb_fpm_round_wb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fpm_round_wb
// Brief    : Self-checking bench for fpm_round_wb with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpm_round_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp_a = 5'd0;
    logic [4:0]  in_exp_b = 5'd0;
    logic [21:0] in_prod = 22'd0;
    logic [2:0]  in_tag = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_tag;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;

    always #5 clk = ~clk;

    fpm_round_wb dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp_a    (in_exp_a),
        .in_exp_b    (in_exp_b),
        .in_prod     (in_prod),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  tag;
        logic        ovf;
        logic        unf;
        logic        inx;
    } exp_t;

    exp_t q[$];
    bit   pend;
    int   n_vec;
    int   n_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Rounding done on integer values: shift, remainder against half an ulp.
    function automatic exp_t model(input bit sg, input int ea, input int eb, input int pr,
                                   input logic [2:0] tg);
        exp_t r;
        int inc, sh, m, rem, half, sum, c, e;
        bit g, s, rup;
        inc  = (pr >= 2097152) ? 1 : 0;
        sh   = 10 + inc;
        m    = (pr >> sh) % 1024;
        rem  = pr % (1 << sh);
        half = 1 << (sh - 1);
        g    = (rem >= half);
        s    = ((rem % half) != 0);
        rup  = g && (s || ((m % 2) == 1));
        sum  = m + int'(rup);
        c    = sum / 1024;
        m    = sum % 1024;
        e    = ea + eb - 15 + inc + c;
        r.tag = tg;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.inx = 1'b0;
        if (ea == 0 || eb == 0) begin
            r.res = sg ? 16'h8000 : 16'h0000;
        end else if (ea == 31 || eb == 31) begin
            r.res = sg ? 16'hFC00 : 16'h7C00;
        end else if (e >= 31) begin
            r.res = sg ? 16'hFC00 : 16'h7C00;
            r.ovf = 1'b1;
            r.inx = 1'b1;
        end else if (e <= 0) begin
            r.res = sg ? 16'h8000 : 16'h0000;
            r.unf = 1'b1;
            r.inx = 1'b1;
        end else begin
            r.res = 16'((sg ? 32768 : 0) + e * 1024 + m);
            r.inx = (rem != 0);
        end
        return r;
    endfunction

    // One clock cycle: drive at posedge+1, check, advance to next posedge+1.
    task automatic cycle(input bit iv, input bit sg, input logic [4:0] ea, input logic [4:0] eb,
                         input logic [21:0] pr, input logic [2:0] tg, input bit ordy,
                         output bit acc);
        bit   fout;
        exp_t h;
        in_valid  = iv;
        in_sign   = sg;
        in_exp_a  = ea;
        in_exp_b  = eb;
        in_prod   = pr;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 4));
        check_eq("out_valid", 32'(out_valid), 32'((q.size() - int'(pend)) > 0));
        if (out_valid && q.size() > 0) begin
            h = q[0];
            check_eq("result", 32'(out_result), 32'(h.res));
            check_eq("tag", 32'(out_tag), 32'(h.tag));
            check_eq("flags", 32'({out_ovf, out_unf, out_inexact}), 32'({h.ovf, h.unf, h.inx}));
        end
        acc  = iv && in_ready;
        fout = out_valid && ordy;
        @(posedge clk);
        #1;
        if (fout && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(model(sg, int'(ea), int'(eb), int'(pr), tg));
        pend = acc;
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        cycle(1'b0, 1'b0, 5'd0, 5'd0, 22'd0, 3'd0, ordy, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
        check_eq("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_result", 32'(out_result), 32'd0);
        check_eq("rst_tag_flags", 32'({out_tag, out_ovf, out_unf, out_inexact}), 32'd0);
        q.delete();
        pend = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string nm, input bit sg, input logic [4:0] ea,
                            input logic [4:0] eb, input logic [21:0] pr,
                            input logic [15:0] xr, input logic [2:0] xf);
        bit acc;
        cycle(1'b1, sg, ea, eb, pr, 3'd5, 1'b1, acc);
        check_eq($sformatf("%s_acc", nm), 32'(acc), 32'd1);
        check_eq($sformatf("%s_lat1", nm), 32'(out_valid), 32'd0);
        idle(1'b1);
        check_eq($sformatf("%s_lat2", nm), 32'(out_valid), 32'd1);
        check_eq($sformatf("%s_res", nm), 32'(out_result), 32'(xr));
        check_eq($sformatf("%s_flags", nm), 32'({out_ovf, out_unf, out_inexact}), 32'(xf));
        check_eq($sformatf("%s_tag", nm), 32'(out_tag), 32'd5);
        drain();
    endtask

    initial begin
        bit          acc;
        int          n_acc;
        logic [2:0]  tg;
        logic [4:0]  ea, eb;
        logic [21:0] pr;
        n_vec = 0;
        n_err = 0;
        pend  = 1'b0;
        #2;
        do_reset();

        // Flags vector is {ovf, unf, inexact}
        directed("basic",    1'b0, 5'd15, 5'd15, 22'h240000, 16'h4080, 3'b000);
        directed("tie_up",   1'b0, 5'd15, 5'd15, 22'h200C00, 16'h4002, 3'b001);
        directed("tie_even", 1'b0, 5'd15, 5'd15, 22'h200400, 16'h4000, 3'b001);
        directed("carry",    1'b0, 5'd15, 5'd15, 22'h3FFC00, 16'h4400, 3'b001);
        directed("ovf",      1'b0, 5'd30, 5'd30, 22'h240000, 16'h7C00, 3'b101);
        directed("unf",      1'b1, 5'd1,  5'd1,  22'h100000, 16'h8000, 3'b011);
        directed("zero",     1'b1, 5'd0,  5'd20, 22'h240000, 16'h8000, 3'b000);
        directed("inf",      1'b0, 5'd20, 5'd31, 22'h240000, 16'h7C00, 3'b000);
        directed("zero_inf", 1'b0, 5'd0,  5'd31, 22'h240000, 16'h0000, 3'b000);
        directed("e31",      1'b0, 5'd16, 5'd30, 22'h100000, 16'h7C00, 3'b101);
        directed("e30",      1'b0, 5'd15, 5'd30, 22'h100000, 16'h7800, 3'b000);
        directed("e0",       1'b0, 5'd7,  5'd8,  22'h100000, 16'h0000, 3'b011);
        directed("e1",       1'b0, 5'd8,  5'd8,  22'h100000, 16'h0400, 3'b000);

        // Backpressure: six offers with the consumer stalled
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            tg = 3'(n_acc);
            cycle(1'b1, 1'b0, 5'd15, 5'd15, 22'($urandom_range(1024, 2047) * $urandom_range(1024, 2047)),
                  tg, 1'b0, acc);
            if (acc) n_acc++;
        end
        check_eq("bp_accepted", 32'(n_acc), 32'd4);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check_eq("bp_order_tag", 32'(out_tag), 32'(k));
            idle(1'b1);
        end
        drain();

        // Reset with three results pending
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 5'd14, 5'd16, 22'h2A5A5A, 3'(k), 1'b0, acc);
        idle(1'b0);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        for (int k = 0; k < 5; k++) idle(1'b1);
        check_eq("post_rst_stale", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) < 6) begin
                ea = 5'($urandom_range(8, 22));
                eb = 5'($urandom_range(8, 22));
            end else begin
                ea = 5'($urandom_range(0, 31));
                eb = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 9) < 7)
                pr = 22'($urandom_range(1024, 2047) * $urandom_range(1024, 2047));
            else
                pr = 22'($urandom);
            cycle(($urandom_range(0, 9) < 7), 1'($urandom), ea, eb, pr, 3'($urandom),
                  ($urandom_range(0, 9) < 6), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpm_round_wb.md
FPM_ROUND_WB -- requirements
Module: fpm_round_wb

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  raw multiplier product is presented.
REQ-004 in_ready  output  1  block can accept the presented product.
REQ-005 in_sign  input  1  result sign, already XORed upstream.
REQ-006 in_exp_a, in_exp_b  input  5 each  biased exponents of the operands, bias 15.
REQ-007 in_prod  input  22  raw 11x11 significand product, hidden bits included.
REQ-008 in_tag  input  3  destination register tag; passed through unchanged.
REQ-009 out_valid  output  1  rounded result is available at the FIFO head.
REQ-010 out_ready  input  1  writeback accepts the head entry.
REQ-011 out_result  output  16  IEEE half-precision result.
REQ-012 out_tag  output  3  tag of the head entry.
REQ-013 out_ovf, out_unf, out_inexact  output  1 each  flags of the head entry.

Function
REQ-014 The block SHALL have two parts: a stage-1 register S1 (valid, sign, exponents, product, tag) and a 4-entry in-order output FIFO.
REQ-015 The input handshake fires when in_valid=1 and in_ready=1; the input is then captured into S1 at that edge.
REQ-016 in_ready SHALL be 1 when (fifo_count + s1_valid) < 4, using registered values only (no combinational path from out_ready).
REQ-017 On each edge with S1 valid, the S1 entry is rounded and written into the FIFO.
  - S1 then either takes the new input or clears.
  - Space is guaranteed by REQ-016.
REQ-018 Latency: input accepted at edge N -> out_valid=1 after edge N+1 when the FIFO is empty; sustained throughput is 1 per cycle with out_ready=1.
REQ-019 An output pop occurs when out_valid=1 and out_ready=1; a push and a pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-020 out_valid = (fifo_count != 0); the out_* data fields show the head entry and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Normalisation:
  - if prod[21]=1: mant=prod[20:11], g=prod[10], s=|prod[9:0], inc=1;
  - else: mant=prod[19:10], g=prod[9], s=|prod[8:0], inc=0.
REQ-022 Rounding is round-to-nearest-even: rup = g & (s | mant[0]).
  - mant+rup is computed 11 bits wide.
  - On carry-out: mantissa = 0 and carry c = 1; else c = 0.
REQ-023 Exponent: e = exp_a + exp_b - 15 + inc + c, computed 7-bit signed with no wrap.
REQ-024 Special cases, in priority order:
  - Either exponent = 0: result {sign,15'b0}, all flags 0.
  - Either exponent = 31: result {sign,5'h1F,10'b0}, all flags 0.
  - e >= 31: result {sign,5'h1F,10'b0}, ovf=1, inexact=1.
  - e <= 0: result {sign,15'b0}, unf=1, inexact=1 (flush; no subnormals).
  - Otherwise: result {sign,e[4:0],mant}, inexact = g|s.
REQ-025 in_tag SHALL travel with its result unmodified.

Reset
REQ-026 While rst=1:
  - s1_valid=0, fifo_count=0, FIFO pointers=0;
  - out_valid=0, in_ready=0;
  - out_result=0, out_tag=0, all flags 0.
REQ-027 After rst deasserts, in_ready=1 from the first clock edge; an assertion mid-transfer discards every in-flight entry, and no partial result is ever emitted.

Verification
REQ-028 Bench scenario, basic multiply: exps 15/15, prod=0x240000, sign 0 -> 0x4080, flags 0, out_valid two edges after accept.
REQ-029 Bench scenario, rounding tie: exps 15/15, prod=0x200C00 -> 0x4002, inexact=1; mantissa carry: prod=0x3FFC00 -> 0x4400, inexact=1.
REQ-030 Bench scenario, overflow and underflow:
  - exps 30/30 -> 0x7C00, ovf=1;
  - exps 1/1, prod=0x100000, sign 1 -> 0x8000, unf=1.
REQ-031 Bench scenario, zero and infinity: exp_a=0 -> signed zero, flags 0; exp_b=31 -> signed infinity, flags 0.
REQ-032 Bench scenario, backpressure: out_ready=0 with 6 inputs offered -> exactly 4 accepted, in_ready=0 afterwards; then out_ready=1 -> the 4 results drain in order, tags 0..3.
REQ-033 Bench scenario, reset mid-operation: rst with 3 entries pending -> out_valid=0 immediately; no stale result appears after release.
